// File: rtl/bus_fifo_slave_pkg.sv
// rtl/bus_fifo_slave_pkg.sv - shared bus constants and FIFO register offsets
//
// Contents:
//   BUS_ADDR_WIDTH, DATA_WIDTH  widths of the shared master bus
//   SEL_ENABLE, SEL_DISABLE     levels of the active-low sel_ strobe
//   fifo_ofs_e                  register offsets within the FIFO window
//   STATUS_*_BIT                bit positions inside STATUS above count

package bus_fifo_slave_pkg;

    localparam int BUS_ADDR_WIDTH = 16;
    localparam int DATA_WIDTH     = 32;

    localparam logic SEL_ENABLE  = 1'b0;
    localparam logic SEL_DISABLE = 1'b1;

    typedef enum logic [1:0] {
        FIFO_OFS_DATA   = 2'd0,
        FIFO_OFS_STATUS = 2'd1,
        FIFO_OFS_CTRL   = 2'd2,
        FIFO_OFS_THRESH = 2'd3
    } fifo_ofs_e;

    // STATUS flag positions are relative to AW: count occupies [AW:0].
    localparam int STATUS_EMPTY_OFS = 1;
    localparam int STATUS_FULL_OFS  = 2;
    localparam int STATUS_UNF_OFS   = 3;
    localparam int STATUS_OVF_OFS   = 4;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage array, synchronous write, asynchronous read
//
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  combinational read of mem[raddr]
// Contents are never reset.

module fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_fifo_slave.sv
// rtl/bus_fifo_slave.sv - memory-mapped FIFO responder on the shared master bus
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   asynchronous active-high reset
//   sel_   in   active-low access strobe
//   addr   in   bus address; [1:0] select DATA/STATUS/CTRL/THRESH
//   idata  in   write data
//   rw_    in   1 = read, 0 = write
//   irq    out  threshold interrupt (only when FIFO_IRQ_EN is defined)
//   odata  out  registered read data, zero except the cycle after a read hit
// Optional feature macro: FIFO_IRQ_EN (THRESH register, CTRL bit1 mask, irq).

module bus_fifo_slave
    import bus_fifo_slave_pkg::*;
#(
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int                        DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sel_,
    input  logic [BUS_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     idata,
    input  logic                      rw_,
`ifdef FIFO_IRQ_EN
    output logic                      irq,
`endif
    output logic [DATA_WIDTH-1:0]     odata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  ovf;
    logic                  unf;
    logic                  empty;
    logic                  full;
    logic                  hit;
    logic [1:0]            ofs;
    logic                  do_push;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] status;

`ifdef FIFO_IRQ_EN
    logic [AW:0] thresh;
    logic        irq_mask;
`endif

    assign hit   = (sel_ == SEL_ENABLE) &&
                   (addr[BUS_ADDR_WIDTH-1:2] == BASE_ADDR[BUS_ADDR_WIDTH-1:2]);
    assign ofs   = addr[1:0];
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // The array only sees accepted pushes; a write while full never lands.
    assign do_push = hit && !rw_ && (ofs == FIFO_OFS_DATA) && !full;

    fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (idata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_comb begin
        status                      = '0;
        status[AW:0]                = count;
        status[AW+STATUS_EMPTY_OFS] = empty;
        status[AW+STATUS_FULL_OFS]  = full;
        status[AW+STATUS_UNF_OFS]   = unf;
        status[AW+STATUS_OVF_OFS]   = ovf;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            odata  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
`ifdef FIFO_IRQ_EN
            thresh   <= '0;
            irq_mask <= 1'b0;
`endif
        end else begin
            // odata is a one-cycle pulse: cleared unless this cycle is a read hit.
            odata <= '0;
            if (hit) begin
                if (rw_) begin
                    case (ofs)
                        FIFO_OFS_DATA: begin
                            if (!empty) begin
                                odata  <= mem_rdata;
                                rd_ptr <= rd_ptr + AW'(1);
                                count  <= count - (AW+1)'(1);
                            end else begin
                                unf <= 1'b1;
                            end
                        end
                        FIFO_OFS_STATUS: odata <= status;
`ifdef FIFO_IRQ_EN
                        FIFO_OFS_THRESH: odata <= DATA_WIDTH'(thresh);
`endif
                        default: ;
                    endcase
                end else begin
                    case (ofs)
                        FIFO_OFS_DATA: begin
                            if (!full) begin
                                wr_ptr <= wr_ptr + AW'(1);
                                count  <= count + (AW+1)'(1);
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                        FIFO_OFS_CTRL: begin
                            if (idata[0]) begin
                                wr_ptr <= '0;
                                rd_ptr <= '0;
                                count  <= '0;
                                ovf    <= 1'b0;
                                unf    <= 1'b0;
                            end
`ifdef FIFO_IRQ_EN
                            irq_mask <= idata[1];
`endif
                        end
`ifdef FIFO_IRQ_EN
                        FIFO_OFS_THRESH: thresh <= idata[AW:0];
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef FIFO_IRQ_EN
    // Evaluated from registered count/thresh, so irq trails them by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (count >= thresh) && (thresh != '0) && !irq_mask;
        end
    end
`endif

endmodule

// File: tb/tb_bus_fifo_slave.sv
// tb/tb_bus_fifo_slave.sv - directed self-checking bench for bus_fifo_slave

module tb_bus_fifo_slave;
    import bus_fifo_slave_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      sel_ = 1'b1;
    logic [BUS_ADDR_WIDTH-1:0] addr = '0;
    logic [DATA_WIDTH-1:0]     idata = '0;
    logic                      rw_ = 1'b0;
    logic [DATA_WIDTH-1:0]     odata;
`ifdef FIFO_IRQ_EN
    logic                      irq;
`endif

    int checks = 0;
    int errors = 0;

    bus_fifo_slave #(
        .BASE_ADDR (16'h0000),
        .DEPTH     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel_  (sel_),
        .addr  (addr),
        .idata (idata),
        .rw_   (rw_),
`ifdef FIFO_IRQ_EN
        .irq   (irq),
`endif
        .odata (odata)
    );

    always #5 clk = ~clk;

    // STATUS layout for DEPTH=16 (AW=4): count[4:0], empty[5], full[6], unf[7], ovf[8].
    function automatic logic [31:0] st(input int cnt, input bit e, input bit f,
                                       input bit u, input bit o);
        logic [31:0] v;
        v = 32'(cnt) & 32'h1F;
        v[5] = e;
        v[6] = f;
        v[7] = u;
        v[8] = o;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        sel_  = 1'b1;
        addr  = '0;
        rw_   = 1'b0;
        idata = '0;
    endtask

    // One bus cycle; returns 1 time unit after the edge that ends it, so odata
    // holds the registered result of a read access.
    task automatic access(input logic rw, input logic [BUS_ADDR_WIDTH-1:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        sel_  = 1'b0;
        addr  = a;
        rw_   = rw;
        idata = d;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic push(input logic [31:0] d);
        access(1'b0, 16'h0000, d);
    endtask

    task automatic read_reg(input logic [1:0] o);
        access(1'b1, {14'h0, o}, 32'h0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset state and STATUS after reset
        bus_idle();
        reset = 1'b1;
        idle_cycles(3);
        check("reset_odata", odata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        read_reg(2'd1);
        check("status_after_reset", odata, st(0, 1, 0, 0, 0));
        idle_cycles(1);
        check("odata_idle_zero", odata, 32'h0);

        // 2: idle bus must not write; an access outside the window is ignored
        idle_cycles(10);
        access(1'b0, 16'h0100, 32'hFFFF_0000);
        read_reg(2'd1);
        check("status_after_idle", odata, st(0, 1, 0, 0, 0));

        // 3: three pushes then three pops
        push(32'hA1);
        push(32'hB2);
        push(32'hC3);
        read_reg(2'd1);
        check("status_count3", odata, st(3, 0, 0, 0, 0));
        read_reg(2'd0);
        check("pop_a1", odata, 32'hA1);
        read_reg(2'd0);
        check("pop_b2", odata, 32'hB2);
        read_reg(2'd0);
        check("pop_c3", odata, 32'hC3);
        idle_cycles(1);
        check("odata_pulse_clears", odata, 32'h0);
        read_reg(2'd1);
        check("status_drained", odata, st(0, 1, 0, 0, 0));

        // 4: fill to full, overflow, drain across the pointer wrap, underflow
        for (int i = 0; i < 16; i++) push(32'h1000 + 32'(i));
        read_reg(2'd1);
        check("status_full", odata, st(16, 0, 1, 0, 0));
        push(32'hDEAD);
        read_reg(2'd1);
        check("status_ovf", odata, st(16, 0, 1, 0, 1));
        for (int i = 0; i < 16; i++) begin
            read_reg(2'd0);
            check($sformatf("wrap_pop%0d", i), odata, 32'h1000 + 32'(i));
        end
        read_reg(2'd0);
        check("pop_empty_zero", odata, 32'h0);
        read_reg(2'd1);
        check("status_unf", odata, st(0, 1, 0, 1, 1));

        // 5: clear via CTRL bit0
        for (int i = 0; i < 5; i++) push(32'h50 + 32'(i));
        access(1'b0, 16'h0002, 32'h1);
        read_reg(2'd1);
        check("status_after_clear", odata, st(0, 1, 0, 0, 0));
        read_reg(2'd2);
        check("ctrl_reads_zero", odata, 32'h0);
        push(32'h5A);
        read_reg(2'd0);
        check("pop_after_clear", odata, 32'h5A);
        read_reg(2'd1);
        check("status_after_clear_pop", odata, st(0, 1, 0, 0, 0));

`ifdef FIFO_IRQ_EN
        // 6: threshold interrupt and mask
        access(1'b0, 16'h0003, 32'h4);
        read_reg(2'd3);
        check("thresh_readback", odata, 32'h4);
        for (int i = 0; i < 3; i++) push(32'h70 + 32'(i));
        idle_cycles(2);
        check("irq_below_thresh", 32'(irq), 32'h0);
        push(32'h73);
        check("irq_not_yet", 32'(irq), 32'h0);
        idle_cycles(1);
        check("irq_at_thresh", 32'(irq), 32'h1);
        access(1'b0, 16'h0002, 32'h2);
        idle_cycles(1);
        check("irq_masked", 32'(irq), 32'h0);
        access(1'b0, 16'h0002, 32'h0);
        idle_cycles(1);
        check("irq_unmasked", 32'(irq), 32'h1);
`else
        access(1'b0, 16'h0003, 32'h4);
        read_reg(2'd3);
        check("thresh_absent", odata, 32'h0);
        for (int i = 0; i < 4; i++) push(32'h70 + 32'(i));
`endif

        // async reset mid-burst: read STATUS so odata is nonzero, then reset
        read_reg(2'd1);
        check("status_before_reset", odata, st(4, 0, 0, 0, 0));
        reset = 1'b1;
        #1;
        check("odata_async_reset", odata, 32'h0);
`ifdef FIFO_IRQ_EN
        check("irq_async_reset", 32'(irq), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b0;
        read_reg(2'd1);
        check("status_after_async_reset", odata, st(0, 1, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
